// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: locks onto frame sync, assembles NCH slots of
// SLOT_W bits (MSB first) in a shadow register and publishes each complete frame.
module tdm_demux #(
  parameter int NCH    = 4,
  parameter int SLOT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    din,
  input  logic                    din_valid,
  input  logic                    fsync,
  output logic [NCH*SLOT_W-1:0]   frame_out,
  output logic                    frame_valid,
  output logic                    sync_err,
  output logic                    locked
);

  localparam int FW = NCH * SLOT_W;
  localparam int CW = $clog2(FW);

  typedef enum logic {HUNT, RECV} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [FW-1:0]   shadow_reg;
  logic [FW-1:0]   shadow_next;
  logic [CW-1:0]   wr_idx;

  // An fsync beat always lands at beat 0, whatever the counter says.
  assign wr_idx = fsync ? '0 : cnt_reg;

  // Beat gi maps to a fixed frame bit; the mapping is a permutation, so each
  // shadow bit has exactly one driver.
  generate
    for (genvar gi = 0; gi < FW; gi++) begin : g_pos
      localparam int P = (gi / SLOT_W) * SLOT_W + SLOT_W - 1 - (gi % SLOT_W);
      assign shadow_next[P] = (wr_idx == CW'(gi)) ? din : shadow_reg[P];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= HUNT;
      cnt_reg     <= '0;
      shadow_reg  <= '0;
      frame_out   <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        case (state_reg)
          HUNT: begin
            if (fsync) begin
              shadow_reg <= shadow_next;
              cnt_reg    <= CW'(1);
              state_reg  <= RECV;
              locked     <= 1'b1;
            end
          end
          RECV: begin
            if (fsync && cnt_reg != '0) begin
              // Early sync wins over completion: restart on this beat.
              sync_err   <= 1'b1;
              shadow_reg <= shadow_next;
              cnt_reg    <= CW'(1);
            end else if (!fsync && cnt_reg == '0) begin
              sync_err   <= 1'b1;
              state_reg  <= HUNT;
              locked     <= 1'b0;
            end else begin
              shadow_reg <= shadow_next;
              if (cnt_reg == CW'(FW - 1)) begin
                frame_out   <= shadow_next;
                frame_valid <= 1'b1;
                cnt_reg     <= '0;
              end else begin
                cnt_reg <= cnt_reg + CW'(1);
              end
            end
          end
          default: begin
            state_reg <= HUNT;
            locked    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (NCH=4, SLOT_W=4) with a queue of expected frames.
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        fsync = 1'b0;
  logic [15:0] frame_out;
  logic        frame_valid;
  logic        sync_err;
  logic        locked;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  tdm_demux #(.NCH(4), .SLOT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .fsync(fsync),
    .frame_out(frame_out), .frame_valid(frame_valid), .sync_err(sync_err),
    .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus followed by checks of the flags and scoreboard.
  task automatic beat(input logic d, input logic fs, input logic v,
                      input logic efv, input logic ese, input logic elk);
    logic [15:0] exp_w;
    din = d; fsync = fs; din_valid = v;
    @(posedge clk); #1;
    chk("frame_valid", 32'(frame_valid), 32'(efv));
    chk("sync_err", 32'(sync_err), 32'(ese));
    chk("locked", 32'(locked), 32'(elk));
    if (frame_valid === 1'b1) begin
      chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        chk("frame_out", 32'(frame_out), 32'(exp_w));
      end
    end
    $display("[TB] t=%0t din=%b fs=%b v=%b -> fv=%b se=%b lk=%b out=%h",
             $time, d, fs, v, frame_valid, sync_err, locked, frame_out);
  endtask

  // Send the first nb beats of a frame with slots s0..s3; a full frame is queued.
  task automatic send(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                      input logic [3:0] s3, input int nb, input logic first_se,
                      input logic gaps);
    logic [15:0] w;
    w = {s3, s2, s1, s0};
    for (int n = 0; n < nb; n++) begin
      if (gaps && n > 0) begin
        repeat ($urandom_range(0, 2)) beat(1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
      end
      if (n == 15) exp_q.push_back(w);
      beat(w[(n / 4) * 4 + 3 - (n % 4)], n == 0, 1'b1, n == 15, (n == 0) && first_se, 1'b1);
    end
  endtask

  initial begin
    // Power-up reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_frame_out", 32'(frame_out), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    rst_n = 1'b1;

    // HUNT rejection
    for (int i = 0; i < 20; i++) beat(1'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("hunt_frame_out", 32'(frame_out), 32'h0);

    // Single continuous frame
    send(4'hA, 4'h5, 4'h3, 4'hC, 16, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("single_hold", 32'(frame_out), 32'hC35A);

    // Back-to-back with random gaps
    send(4'h4, 4'h3, 4'h2, 4'h1, 16, 1'b0, 1'b1);
    send(4'hF, 4'h0, 4'hF, 4'h0, 16, 1'b0, 1'b1);
    chk("b2b_last", 32'(frame_out), 32'h0F0F);

    // Early fsync at beat 7 aborts the partial frame
    send(4'h8, 4'h8, 4'h8, 4'h8, 7, 1'b0, 1'b0);
    send(4'h1, 4'h2, 4'h3, 4'h4, 16, 1'b1, 1'b0);
    chk("early_out", 32'(frame_out), 32'h4321);

    // Missing fsync drops lock; following beats ignored
    beat(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("miss_hold", 32'(frame_out), 32'h4321);
    send(4'hF, 4'hF, 4'hF, 4'hF, 16, 1'b0, 1'b0);
    chk("relock_out", 32'(frame_out), 32'hFFFF);

    // Asynchronous reset mid-frame, away from any clock edge
    send(4'h5, 4'h5, 4'h5, 4'h5, 5, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_frame_out", 32'(frame_out), 32'h0);
    chk("arst_frame_valid", 32'(frame_valid), 32'h0);
    chk("arst_sync_err", 32'(sync_err), 32'h0);
    chk("arst_locked", 32'(locked), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(4'h9, 4'h6, 4'h0, 4'hE, 16, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_rst_out", 32'(frame_out), 32'hE069);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Receive-side time-division demultiplexer. It takes a single serial bit stream carrying NCH multiplexed channels, locks onto the frame sync, and distributes each slot's bits to a per-channel parallel output register. It sits at the far end of the serial link, after the TDM multiplexer, and hands complete frames to downstream logic as one atomic, registered word.

## Interface
- NCH, default 4: channels (slots) per frame; ≥2.
- SLOT_W, default 4: bits per slot; ≥1.
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  1  serial data bit.
- din_valid  in  1  din/fsync are meaningful this cycle (one beat).
- fsync  in  1  marks the first beat of a frame; ignored when din_valid=0.
- frame_out  out  NCH*SLOT_W  last complete frame; channel k at [k*SLOT_W +: SLOT_W].
- frame_valid  out  1  one-cycle pulse: frame_out just updated.
- sync_err  out  1  one-cycle pulse: framing violation detected.
- locked  out  1  high while in RECV.

## Operation
- Frame: NCH*SLOT_W beats; slot 0 first, slot NCH-1 last; within a slot MSB first.
- Beat n of a frame (n=0..NCH*SLOT_W-1) goes to slot s=n/SLOT_W, bit SLOT_W-1-(n mod SLOT_W), i.e. frame_out[s*SLOT_W + SLOT_W-1-(n mod SLOT_W)].
- Assembly happens in an internal shadow register; frame_out changes only on frame completion, never with partial data.
- Beat counter width clog2(NCH*SLOT_W); wraps to 0 after the last beat.
- States:
  - HUNT: cycles without din_valid&&fsync are discarded. On din_valid&&fsync, the beat is taken as beat 0, counter=1, go RECV.
  - RECV: each din_valid beat is stored at the current counter position, then the counter increments.
    - Last beat (counter=NCH*SLOT_W-1) with fsync=0: copy the assembled frame to frame_out, pulse frame_valid, counter←0, stay RECV.
    - fsync=1 at counter≠0: pulse sync_err, discard the partial frame, take this beat as beat 0 (counter=1), stay RECV. This rule has priority over the last-beat rule, so the frame is not emitted.
    - Counter=0 with fsync=0: pulse sync_err, discard the beat, go HUNT.
    - Counter=0 with fsync=1: normal start of the next frame.
- din_valid=0: no state, counter, or data change; gaps of any length are allowed mid-frame.
- A single-beat frame is impossible (NCH≥2), so frame_valid and sync_err are never asserted together.
- The shadow register is not cleared between frames. Every position is overwritten before use.

## Timing
- Reset values: frame_out=0, frame_valid=0, sync_err=0, locked=0, state=HUNT, counter=0, shadow=0.
- All outputs are registered.
- frame_valid is high exactly one cycle: the cycle after the edge that samples the last beat. frame_out is updated at that same edge.
- frame_out holds until the next complete frame.
- sync_err is high for the one cycle after the edge that samples the offending beat.
- locked: rises the cycle after the fsync beat is sampled in HUNT; falls the cycle after a missing-fsync error.
- Back-to-back frames at full rate (din_valid held high): a frame_valid pulse every NCH*SLOT_W cycles, no bubble.
- Asynchronous reset mid-frame clears everything immediately. After release, the block behaves as from power-up (HUNT), and the partial frame is lost.

## Test plan
Defaults NCH=4, SLOT_W=4.
- Reset check: assert rst_n=0 mid-stream, with no clk edge required → outputs at reset values at once. Release reset, then send one full frame → frame_valid pulses.
- Single frame: fsync on the first beat, slots 0xA,0x5,0x3,0xC MSB-first, continuous → frame_out=16'hC35A. frame_valid high exactly one cycle, one cycle after beat 15. locked=1 from cycle 2.
- Back-to-back with gaps: two frames (0x1234-pattern slots 4,3,2,1 then F,0,F,0), random din_valid gaps, fsync ignored while din_valid=0 → frame_out=16'h1234 then 16'h0F0F. Two pulses, sync_err never set.
- Early fsync: fsync at beat 7, then a full frame of slots 1,2,3,4 → one sync_err pulse, no frame_valid for the aborted frame, then frame_out=16'h4321.
- Missing fsync: after a good frame, next beat has fsync=0 → sync_err pulse, locked=0, following beats ignored. A later fsync frame of 0xF,0xF,0xF,0xF → relock, frame_out=16'hFFFF.
- HUNT rejection: 20 beats with fsync=0 after reset → no frame_valid, no sync_err, locked=0, frame_out=0.
